// File: rtl/lfsr_ctrl_if.sv
// LFSR-side bus: strobes and seed out to the LFSR, current state back.
interface lfsr_ctrl_if;
    logic       lfsr_en;
    logic       lfsr_load;
    logic [7:0] lfsr_seed;
    logic [7:0] lfsr_q;

    modport master (output lfsr_en, output lfsr_load, output lfsr_seed, input lfsr_q);
    modport slave  (input lfsr_en, input lfsr_load, input lfsr_seed, output lfsr_q);
endinterface

// File: rtl/lfsr_ctrl.sv
// LFSR sequencing controller: button-driven load/step/free-run with a
// period checker that flags an LFSR not returning to its seed.
//
// state | meaning
// IDLE  | waiting for a button edge
// LOAD  | lfsr_load strobe is out this cycle
// STEP  | single lfsr_en strobe is out this cycle
// RUN   | free-running, lfsr_en paced by the prescaler
module lfsr_ctrl #(
    parameter logic [7:0] DEF_SEED = 8'h01,
    parameter int         PERIOD   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_step,
    input  logic               btn_run,
    input  logic               btn_load,
    input  logic [7:0]         sw_seed,
    input  logic [1:0]         div_sel,
    lfsr_ctrl_if.master        lfsr,
    output logic               running,
    output logic [7:0]         step_cnt,
    output logic               period_done,
    output logic               seq_err
);
    typedef enum logic [1:0] {IDLE, LOAD, STEP, RUN} state_t;

    localparam logic [7:0] LAST_CNT = 8'(PERIOD - 1);

    state_t     state;
    logic       step_prev, run_prev, load_prev;
    logic       armed;
    logic       step_edge, run_edge, load_edge, load_go;
    logic [7:0] presc;
    logic [7:0] presc_tc;
    logic [7:0] ref_seed;
    logic [7:0] seed_eff;

    // armed stays low for the first clock after reset so a button held
    // through reset release cannot look like a fresh edge
    assign step_edge = armed & btn_step & ~step_prev;
    assign run_edge  = armed & btn_run  & ~run_prev;
    assign load_edge = armed & btn_load & ~load_prev;
    assign load_go   = load_edge & ((state == IDLE) | (state == RUN));
    assign seed_eff  = (sw_seed == 8'h00) ? DEF_SEED : sw_seed;

    // prescaler terminal count for the selected free-run rate
    always_comb begin
        presc_tc = 8'd0;
        case (div_sel)
            2'b00: presc_tc = 8'd0;
            2'b01: presc_tc = 8'd3;
            2'b10: presc_tc = 8'd15;
            2'b11: presc_tc = 8'd255;
            default: presc_tc = 8'd0;
        endcase
    end

    // button history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_prev <= 1'b0;
            run_prev  <= 1'b0;
            load_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            step_prev <= btn_step;
            run_prev  <= btn_run;
            load_prev <= btn_load;
            armed     <= 1'b1;
        end
    end

    // control FSM with registered strobes; load beats run beats step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lfsr.lfsr_en   <= 1'b0;
            lfsr.lfsr_load <= 1'b0;
            lfsr.lfsr_seed <= DEF_SEED;
            ref_seed       <= DEF_SEED;
            presc          <= 8'd0;
            running        <= 1'b0;
        end else begin
            lfsr.lfsr_en   <= 1'b0;
            lfsr.lfsr_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_edge) begin
                        state          <= LOAD;
                        lfsr.lfsr_load <= 1'b1;
                        lfsr.lfsr_seed <= seed_eff;
                        ref_seed       <= seed_eff;
                        presc          <= 8'd0;
                    end else if (run_edge) begin
                        state   <= RUN;
                        running <= 1'b1;
                        presc   <= 8'd0;
                    end else if (step_edge) begin
                        state        <= STEP;
                        lfsr.lfsr_en <= 1'b1;
                    end
                end
                LOAD: state <= IDLE;
                STEP: state <= IDLE;
                RUN: begin
                    if (load_edge) begin
                        state          <= LOAD;
                        running        <= 1'b0;
                        lfsr.lfsr_load <= 1'b1;
                        lfsr.lfsr_seed <= seed_eff;
                        ref_seed       <= seed_eff;
                        presc          <= 8'd0;
                    end else if (run_edge) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (presc == presc_tc) begin
                        lfsr.lfsr_en <= 1'b1;
                        presc        <= 8'd0;
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // step counting, period pulse and sticky sequence check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt    <= 8'd0;
            period_done <= 1'b0;
            seq_err     <= 1'b0;
        end else if (load_go) begin
            step_cnt    <= 8'd0;
            period_done <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            period_done <= lfsr.lfsr_en & (step_cnt == LAST_CNT);
            if (lfsr.lfsr_en) begin
                step_cnt <= (step_cnt == LAST_CNT) ? 8'd0 : step_cnt + 8'd1;
            end
            // the LFSR has absorbed the wrapping strobe by the period_done cycle
            if (period_done && (lfsr.lfsr_q != ref_seed)) begin
                seq_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_ctrl.sv
// Bench for lfsr_ctrl: directed scenarios plus random buttons, checked each
// cycle against a behavioural model and a model LFSR.
module tb_lfsr_ctrl;
    localparam logic [7:0] DEF_SEED = 8'h01;
    localparam int         PERIOD   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_step = 1'b0, btn_run = 1'b0, btn_load = 1'b0;
    logic [7:0] sw_seed = 8'h00;
    logic [1:0] div_sel = 2'b00;
    logic       running, period_done, seq_err;
    logic [7:0] step_cnt;

    lfsr_ctrl_if lif();

    lfsr_ctrl #(.DEF_SEED(DEF_SEED), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst),
        .btn_step(btn_step), .btn_run(btn_run), .btn_load(btn_load),
        .sw_seed(sw_seed), .div_sel(div_sel),
        .lfsr(lif),
        .running(running), .step_cnt(step_cnt),
        .period_done(period_done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model LFSR (x^8+x^6+x^5+x^4+1), driven by the DUT strobes of the ending cycle
    logic [7:0] lfsr_state = 8'h01;
    logic [7:0] lfsr_nxt;
    logic [7:0] corrupt = 8'h00;
    logic       s_en = 1'b0, s_load = 1'b0;
    logic [7:0] s_seed = 8'h01;
    assign lif.lfsr_q = lfsr_state ^ corrupt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    always @(posedge clk) begin
        lfsr_nxt = lfsr_state;
        if (s_load) lfsr_nxt = s_seed;
        else if (s_en) lfsr_nxt = lfsr_next(lfsr_state);
        #1 lfsr_state = lfsr_nxt;
    end

    // behavioural reference
    int         rate [4] = '{1, 4, 16, 256};
    bit         m_prev_s = 0, m_prev_r = 0, m_prev_l = 0, m_armed = 0;
    bit         m_running = 0, m_busy = 0, m_en = 0, m_load = 0, m_pdone = 0, m_err = 0;
    logic [7:0] m_seed = DEF_SEED, m_ref = DEF_SEED, m_lq;
    int         m_cnt = 0, m_since = 0;
    bit         e_s, e_r, e_l, m_en_was;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev_s = 0; m_prev_r = 0; m_prev_l = 0; m_armed = 0;
            m_running = 0; m_busy = 0; m_en = 0; m_load = 0; m_pdone = 0; m_err = 0;
            m_seed = DEF_SEED; m_ref = DEF_SEED; m_cnt = 0; m_since = 0;
        end else begin
            m_lq = lif.lfsr_q;
            e_s = m_armed && btn_step && !m_prev_s;
            e_r = m_armed && btn_run  && !m_prev_r;
            e_l = m_armed && btn_load && !m_prev_l;
            m_en_was = m_en;
            if (m_pdone && m_lq != m_ref) m_err = 1;
            m_pdone = m_en_was && (m_cnt == PERIOD - 1);
            if (m_en_was) m_cnt = (m_cnt + 1) % PERIOD;
            m_load = 0;
            if (m_busy) begin
                m_busy = 0; m_en = 0;
            end else if (e_l) begin
                m_load = 1; m_seed = (sw_seed == 0) ? DEF_SEED : sw_seed; m_ref = m_seed;
                m_cnt = 0; m_since = 0; m_err = 0; m_pdone = 0;
                m_running = 0; m_busy = 1; m_en = 0;
            end else if (m_running) begin
                if (e_r) begin
                    m_running = 0; m_en = 0;
                end else begin
                    m_en = (m_since == rate[div_sel] - 1);
                    m_since = m_en ? 0 : (m_since + 1) % 256;
                end
            end else if (e_r) begin
                m_running = 1; m_since = 0; m_en = 0;
            end else if (e_s) begin
                m_en = 1; m_busy = 1;
            end else begin
                m_en = 0;
            end
            m_prev_s = btn_step; m_prev_r = btn_run; m_prev_l = btn_load; m_armed = 1;
        end
    end

    // per-cycle compare and event counters
    int         en_count = 0, load_count = 0, pdone_count = 0;
    logic [7:0] last_seed = 8'h00;

    always @(negedge clk) begin
        s_en = lif.lfsr_en; s_load = lif.lfsr_load; s_seed = lif.lfsr_seed;
        if (lif.lfsr_en) en_count++;
        if (lif.lfsr_load) begin load_count++; last_seed = lif.lfsr_seed; end
        if (period_done) pdone_count++;
        check("lfsr_en",     lif.lfsr_en,   m_en);
        check("lfsr_load",   lif.lfsr_load, m_load);
        check("lfsr_seed",   lif.lfsr_seed, m_seed);
        check("running",     running,       m_running);
        check("step_cnt",    step_cnt,      m_cnt);
        check("period_done", period_done,   m_pdone);
        check("seq_err",     seq_err,       m_err);
        check("en_load_excl", lif.lfsr_en & lif.lfsr_load, 0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: btn_load = 1'b1;
            1: btn_run  = 1'b1;
            default: btn_step = 1'b1;
        endcase
        @(negedge clk);
        btn_load = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
    endtask

    task automatic clear_counts();
        @(posedge clk);
        #1;
        en_count = 0; load_count = 0; pdone_count = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        idle(3);
        check("rst_seed", lif.lfsr_seed, 8'h01);
        check("rst_running", running, 0);
        check("rst_step_cnt", step_cnt, 0);
        rst = 1'b0;
        idle(2);

        // zero seed falls back to the default
        clear_counts();
        sw_seed = 8'h00;
        pulse(0);
        idle(3);
        check("load_pulses", load_count, 1);
        check("load_seed", last_seed, 8'h01);
        check("load_step_cnt", step_cnt, 0);

        // three single steps
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            pulse(2);
            idle(2);
        end
        check("step_pulses", en_count, 3);
        check("step_cnt_3", step_cnt, 3);

        // divide-by-4 free run for 40 cycles
        clear_counts();
        div_sel = 2'b01;
        pulse(1);
        idle(39);
        pulse(1);
        idle(4);
        check("run_pulses", en_count, 10);
        check("run_stopped", running, 0);

        // full period with a healthy LFSR
        sw_seed = 8'h5A;
        pulse(0);
        idle(3);
        clear_counts();
        div_sel = 2'b00;
        pulse(1);
        idle(290);
        pulse(1);
        idle(4);
        check("period_pulses", pdone_count, 1);
        check("period_ok_err", seq_err, 0);

        // full period with a corrupted feedback value
        pulse(0);
        idle(3);
        corrupt = 8'h01;
        clear_counts();
        pulse(1);
        idle(290);
        pulse(1);
        idle(4);
        check("corrupt_pulses", pdone_count, 1);
        check("corrupt_err", seq_err, 1);
        idle(20);
        check("corrupt_err_sticky", seq_err, 1);
        corrupt = 8'h00;

        // load and run edges together while running
        div_sel = 2'b01;
        pulse(1);
        idle(10);
        clear_counts();
        @(negedge clk);
        btn_load = 1'b1; btn_run = 1'b1;
        @(negedge clk);
        btn_load = 1'b0; btn_run = 1'b0;
        idle(5);
        check("simul_loads", load_count, 1);
        check("simul_running", running, 0);
        clear_counts();
        pulse(2);
        idle(3);
        check("simul_idle_step", en_count, 1);

        // asynchronous reset mid-run, run button held through release
        div_sel = 2'b00;
        pulse(1);
        idle(5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_en", lif.lfsr_en, 0);
        check("arst_load", lif.lfsr_load, 0);
        check("arst_seed", lif.lfsr_seed, 8'h01);
        check("arst_running", running, 0);
        check("arst_step_cnt", step_cnt, 0);
        check("arst_pdone", period_done, 0);
        check("arst_err", seq_err, 0);
        btn_run = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(6);
        check("held_run_no_start", running, 0);
        btn_run = 1'b0;
        idle(2);

        // random buttons, rates, seeds and occasional feedback corruption
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 24) == 0) btn_run  = ~btn_run;
            if ($urandom_range(0, 39) == 0) btn_load = ~btn_load;
            if ($urandom_range(0, 49) == 0) div_sel  = 2'($urandom_range(0, 3));
            sw_seed = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 499) == 0) corrupt = 8'($urandom_range(0, 3));
        end
        btn_step = 1'b0; btn_run = 1'b0; btn_load = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter DEF_SEED, 8'h01, seed used after reset and substituted for any zero seed.
REQ-002 Parameter PERIOD, 255, number of steps in one full LFSR sequence.
REQ-003 Port clk, input, 1, single rising-edge clock.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port btn_step, input, 1, level synchronous to clk; rising edge requests a single step.
REQ-006 Port btn_run, input, 1, level synchronous to clk; rising edge toggles free-run.
REQ-007 Port btn_load, input, 1, level synchronous to clk; rising edge loads sw_seed.
REQ-008 Port sw_seed, input, 8, seed value sampled on a load edge.
REQ-009 Port div_sel, input, 2, free-run rate: 00 every cycle, 01 every 4, 10 every 16, 11 every 256 cycles.
REQ-010 Port lfsr_q, input, 8, current LFSR state fed back from the LFSR.
REQ-011 Port lfsr_en, output, 1, registered one-cycle LFSR advance strobe.
REQ-012 Port lfsr_load, output, 1, registered one-cycle LFSR seed-load strobe.
REQ-013 Port lfsr_seed, output, 8, registered seed value, valid while lfsr_load=1.
REQ-014 Port running, output, 1, high while in RUN state.
REQ-015 Port step_cnt, output, 8, steps issued since the last load.
REQ-016 Port period_done, output, 1, one-cycle pulse when step_cnt wraps.
REQ-017 Port seq_err, output, 1, sticky flag; LFSR not back at seed after PERIOD steps.

Function
REQ-018 Each button SHALL have a previous-value register; edge = btn & ~btn_prev, with at most one action per edge.
REQ-019 The FSM SHALL have states IDLE, LOAD, STEP and RUN.
REQ-020 Edge priority SHALL be load > run > step; lower-priority edges in the same cycle are dropped.
REQ-021 IDLE + load edge -> LOAD; lfsr_load=1 for exactly the next cycle, then return to IDLE.
REQ-022 The loaded seed SHALL be sw_seed, or DEF_SEED when sw_seed==0; it is also stored as the reference seed.
REQ-023 A load SHALL clear step_cnt, the prescaler and seq_err.
REQ-024 IDLE + step edge -> STEP; lfsr_en=1 for exactly the next cycle, then return to IDLE.
REQ-025 IDLE + run edge -> RUN; prescaler cleared on entry.
REQ-026 In RUN, lfsr_en SHALL pulse one cycle each time the prescaler reaches its div_sel terminal count (0, 3, 15, 255), then the prescaler wraps to 0.
REQ-027 RUN + run edge -> IDLE; no lfsr_en is issued in the exit cycle.
REQ-028 RUN + load edge -> LOAD, then IDLE; running drops.
REQ-029 Step edges in RUN SHALL be ignored.
REQ-030 lfsr_en and lfsr_load SHALL never be high in the same cycle.
REQ-031 step_cnt SHALL increment with every lfsr_en pulse and wrap from PERIOD-1 to 0.
REQ-032 period_done SHALL pulse in the cycle after the wrapping lfsr_en pulse.
REQ-033 In the same cycle as period_done, seq_err SHALL set if lfsr_q != reference seed.
REQ-034 A div_sel change mid-RUN SHALL take effect at the next prescaler compare without clearing the prescaler; an overshoot waits for the 8-bit wrap.

Reset
REQ-035 rst SHALL asynchronously force IDLE and the button-prev registers to 0.
REQ-036 rst SHALL force lfsr_en=0, running=0, step_cnt=0, period_done=0, seq_err=0 and prescaler=0.
REQ-037 rst SHALL force lfsr_load=0, lfsr_seed=DEF_SEED and reference seed=DEF_SEED.
REQ-038 A button held high through reset release SHALL NOT produce an edge.

Verification
REQ-039 Load scenario: sw_seed=8'h00, pulse btn_load -> one cycle lfsr_load=1, lfsr_seed=8'h01, step_cnt=0.
REQ-040 Step scenario: three btn_step pulses in IDLE -> exactly three single-cycle lfsr_en pulses, step_cnt=3.
REQ-041 Run scenario: div_sel=01, run edge, wait 40 cycles, run edge -> lfsr_en every 4th cycle (10 pulses), running returns to 0.
REQ-042 Period scenario: seed 8'h5A, div_sel=00, run 255 steps with a model LFSR -> period_done pulses once, seq_err=0; repeat with a corrupted lfsr_q -> seq_err=1 and stays set.
REQ-043 Simultaneous-edge scenario: btn_load and btn_run rise in the same cycle in RUN -> load only, FSM ends in IDLE.
REQ-044 Reset scenario: assert rst mid-RUN asynchronously -> all outputs at reset values before the next clock edge; btn_run held high at release -> no run start.
